qenc_mvd_bin_fsm: RTL and testbench

//  Encoder-side MVD binarizer for the CABAC encoder. It turns one signed MVD pair (x,y) into the HEVC
//  mvd_coding() bin sequence: abs_mvd_greater0/1_flag as context-coded bins, then abs_mvd_minus2
//  (EG1) and mvd_sign_flag as bypass bins. Bins go out one at a time over a valid/ready link to the

---
 rtl/qenc_mvd_bin_fsm_pkg.sv | 61 ++++++
 rtl/qenc_mvd_bin_fsm_eg.sv | 75 +++++++
 rtl/qenc_mvd_bin_fsm.sv | 161 ++++++++++++++++
 tb/tb_qenc_mvd_bin_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qenc_mvd_bin_fsm_pkg.sv
// Shared encoder CABAC package: MVD FSM states, EG serializer phases,
// slice-type encodings and the abs_mvd_greater0/1 context tables.
package qenc_mvd_bin_fsm_pkg;

  localparam logic [1:0] SLICE_B = 2'd0;
  localparam logic [1:0] SLICE_P = 2'd1;
  localparam logic [1:0] SLICE_I = 2'd2;

  localparam logic [9:0] CTXIDX_ABS_MVD_GT0_FLAG [3] =
    '{10'd200, 10'd201, 10'd202};
  localparam logic [9:0] CTXIDX_ABS_MVD_GT1_FLAG [3] =
    '{10'd203, 10'd204, 10'd205};

  typedef enum logic [3:0] {
    S_IDLE,
    S_GT0_0,
    S_GT0_1,
    S_GT1_0,
    S_GT1_1,
    S_MINUS2_0,
    S_SIGN_0,
    S_MINUS2_1,
    S_SIGN_1,
    S_DONE
  } t_state_mvd_enc;

  typedef enum logic [1:0] {
    EG_IDLE,
    EG_PFX,
    EG_SFX
  } t_eg_phase;

  function automatic logic [1:0] init_type(
    input logic [1:0] st,
    input logic       ci
  );
    case (st)
      SLICE_P: return ci ? 2'd2 : 2'd1;
      SLICE_B: return ci ? 2'd1 : 2'd2;
      SLICE_I: return 2'd0;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [9:0] ctx_gt0(input logic [1:0] t);
    case (t)
      2'd1:    return CTXIDX_ABS_MVD_GT0_FLAG[1];
      2'd2:    return CTXIDX_ABS_MVD_GT0_FLAG[2];
      default: return CTXIDX_ABS_MVD_GT0_FLAG[0];
    endcase
  endfunction

  function automatic logic [9:0] ctx_gt1(input logic [1:0] t);
    case (t)
      2'd1:    return CTXIDX_ABS_MVD_GT1_FLAG[1];
      2'd2:    return CTXIDX_ABS_MVD_GT1_FLAG[2];
      default: return CTXIDX_ABS_MVD_GT1_FLAG[0];
    endcase
  endfunction

endpackage

// File: rtl/qenc_mvd_bin_fsm_eg.sv
// k-th order Exp-Golomb bin serializer (qenc_eg1_bin).
// load/value/k0 start a code; bins leave on bin_vld/bin_rdy; last marks the final bin.
module qenc_eg1_bin
  import qenc_mvd_bin_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [4:0]  k0,
  output logic        bin_val,
  output logic        bin_vld,
  input  logic        bin_rdy,
  output logic        last
);

  t_eg_phase   r_phase;
  logic [15:0] r_v;
  logic [4:0]  r_k;

  logic [16:0] w_thr;
  logic        w_pfx1;
  logic [3:0]  w_sidx;
  logic        w_acc;

  assign w_thr  = 17'd1 << r_k;
  assign w_pfx1 = {1'b0, r_v} >= w_thr;
  assign w_sidx = 4'(r_k - 5'd1);
  assign w_acc  = bin_vld && bin_rdy;

  always_comb begin
    bin_vld = 1'b0;
    bin_val = 1'b0;
    last    = 1'b0;
    case (r_phase)
      EG_PFX: begin
        bin_vld = 1'b1;
        bin_val = w_pfx1;
        last    = !w_pfx1 && (r_k == 5'd0);
      end
      EG_SFX: begin
        bin_vld = 1'b1;
        bin_val = r_v[w_sidx];
        last    = (r_k == 5'd1);
      end
      default: ;
    endcase
  end

  // r_k doubles as the suffix bit counter once the prefix ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= EG_IDLE;
      r_v     <= '0;
      r_k     <= '0;
    end else if (load) begin
      r_phase <= EG_PFX;
      r_v     <= value;
      r_k     <= k0;
    end else if (w_acc) begin
      if (r_phase == EG_PFX) begin
        if (w_pfx1) begin
          r_v <= r_v - w_thr[15:0];
          r_k <= r_k + 5'd1;
        end else begin
          r_phase <= (r_k == 5'd0) ? EG_IDLE : EG_SFX;
        end
      end else begin
        r_k <= r_k - 5'd1;
        if (r_k == 5'd1) r_phase <= EG_IDLE;
      end
    end
  end

endmodule

// File: rtl/qenc_mvd_bin_fsm.sv
// MVD binarizer: one signed (x,y) pair -> mvd_coding() bins over valid/ready.
// In: start/mvd/slice info, bin_rdy. Out: bin_val/vld/ctx_addr/ep_mode, busy, done.
module qenc_mvd_bin_fsm
  import qenc_mvd_bin_fsm_pkg::*;
#(
  parameter int MVD_W  = 16,
  parameter int CTX_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mvd_start,
  input  logic [MVD_W-1:0]  mvd_x,
  input  logic [MVD_W-1:0]  mvd_y,
  input  logic [1:0]        slice_type,
  input  logic              cabac_init_flag,
  output logic              bin_val,
  output logic              bin_vld,
  input  logic              bin_rdy,
  output logic [CTX_AW-1:0] bin_ctx_addr,
  output logic              bin_ep_mode,
  output logic              busy,
  output logic              mvd_done_intr
);

  t_state_mvd_enc   r_state;
  t_state_mvd_enc   w_next;
  logic [MVD_W-1:0] r_abs0;
  logic [MVD_W-1:0] r_abs1;
  logic             r_sign0;
  logic             r_sign1;
  logic [1:0]       r_init;

  logic w_nz0, w_nz1, w_big0, w_big1, w_acc;
  logic w_eg_load, w_eg_val, w_eg_vld, w_eg_rdy, w_eg_last;
  logic [15:0] w_eg_value;
  logic [9:0]  w_ctx;
  t_state_mvd_enc w_aft_s0, w_aft_g11, w_aft_g10;

  assign w_nz0  = |r_abs0;
  assign w_nz1  = |r_abs1;
  assign w_big0 = r_abs0 > MVD_W'(1);
  assign w_big1 = r_abs1 > MVD_W'(1);
  assign w_acc  = bin_vld && bin_rdy;

  // successor chains that let skipped states cost no cycle
  assign w_aft_s0  = w_big1 ? S_MINUS2_1 : (w_nz1 ? S_SIGN_1 : S_DONE);
  assign w_aft_g11 = w_big0 ? S_MINUS2_0 : (w_nz0 ? S_SIGN_0 : w_aft_s0);
  assign w_aft_g10 = w_nz1 ? S_GT1_1 : w_aft_g11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abs0  <= '0;
      r_abs1  <= '0;
      r_sign0 <= 1'b0;
      r_sign1 <= 1'b0;
      r_init  <= '0;
    end else if (r_state == S_IDLE && mvd_start) begin
      r_abs0  <= mvd_x[MVD_W-1] ? -mvd_x : mvd_x;
      r_abs1  <= mvd_y[MVD_W-1] ? -mvd_y : mvd_y;
      r_sign0 <= mvd_x[MVD_W-1];
      r_sign1 <= mvd_y[MVD_W-1];
      r_init  <= init_type(slice_type, cabac_init_flag);
    end
  end

  always_comb begin
    w_next        = r_state;
    bin_vld       = 1'b0;
    bin_val       = 1'b0;
    bin_ep_mode   = 1'b0;
    w_ctx         = '0;
    w_eg_rdy      = 1'b0;
    busy          = 1'b1;
    mvd_done_intr = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (mvd_start) w_next = S_GT0_0;
      end
      S_GT0_0: begin
        bin_vld = 1'b1;
        bin_val = w_nz0;
        w_ctx   = ctx_gt0(r_init);
        if (w_acc) w_next = S_GT0_1;
      end
      S_GT0_1: begin
        bin_vld = 1'b1;
        bin_val = w_nz1;
        w_ctx   = ctx_gt0(r_init);
        if (w_acc) w_next = w_nz0 ? S_GT1_0 : w_aft_g10;
      end
      S_GT1_0: begin
        bin_vld = 1'b1;
        bin_val = w_big0;
        w_ctx   = ctx_gt1(r_init);
        if (w_acc) w_next = w_aft_g10;
      end
      S_GT1_1: begin
        bin_vld = 1'b1;
        bin_val = w_big1;
        w_ctx   = ctx_gt1(r_init);
        if (w_acc) w_next = w_aft_g11;
      end
      S_MINUS2_0, S_MINUS2_1: begin
        bin_vld     = w_eg_vld;
        bin_val     = w_eg_val;
        bin_ep_mode = 1'b1;
        w_eg_rdy    = bin_rdy;
        if (w_acc && w_eg_last)
          w_next = (r_state == S_MINUS2_0) ? S_SIGN_0 : S_SIGN_1;
      end
      S_SIGN_0: begin
        bin_vld     = 1'b1;
        bin_val     = r_sign0;
        bin_ep_mode = 1'b1;
        if (w_acc) w_next = w_aft_s0;
      end
      S_SIGN_1: begin
        bin_vld     = 1'b1;
        bin_val     = r_sign1;
        bin_ep_mode = 1'b1;
        if (w_acc) w_next = S_DONE;
      end
      S_DONE: begin
        busy          = 1'b0;
        mvd_done_intr = 1'b1;
        w_next        = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  assign bin_ctx_addr = CTX_AW'(w_ctx);

  // load on the handshake that enters a MINUS2 state so its first bin is ready next cycle
  assign w_eg_load  = w_acc && (w_next != r_state) &&
                      (w_next == S_MINUS2_0 || w_next == S_MINUS2_1);
  assign w_eg_value = (w_next == S_MINUS2_0) ? 16'(r_abs0 - MVD_W'(2))
                                             : 16'(r_abs1 - MVD_W'(2));

  qenc_eg1_bin u_eg1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_eg_load),
    .value   (w_eg_value),
    .k0      (5'd1),
    .bin_val (w_eg_val),
    .bin_vld (w_eg_vld),
    .bin_rdy (w_eg_rdy),
    .last    (w_eg_last)
  );

endmodule

// File: tb/tb_qenc_mvd_bin_fsm.sv
// Bench for qenc_mvd_bin_fsm: directed cases plus random MVDs
// against a bin-list model built from the mvd_coding() rules.
module tb_qenc_mvd_bin_fsm;
  import qenc_mvd_bin_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mvd_start;
  logic [15:0] mvd_x, mvd_y;
  logic [1:0]  slice_type;
  logic        cabac_init_flag;
  logic        bin_val, bin_vld, bin_rdy, bin_ep_mode;
  logic [9:0]  bin_ctx_addr;
  logic        busy, mvd_done_intr;

  int ncmp = 0;
  int nfail = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  qenc_mvd_bin_fsm #(.MVD_W(16), .CTX_AW(10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mvd_start       (mvd_start),
    .mvd_x           (mvd_x),
    .mvd_y           (mvd_y),
    .slice_type      (slice_type),
    .cabac_init_flag (cabac_init_flag),
    .bin_val         (bin_val),
    .bin_vld         (bin_vld),
    .bin_rdy         (bin_rdy),
    .bin_ctx_addr    (bin_ctx_addr),
    .bin_ep_mode     (bin_ep_mode),
    .busy            (busy),
    .mvd_done_intr   (mvd_done_intr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] mk(input int v, input bit ep,
                                     input logic [9:0] ctx);
    return {v != 0, ep, ctx};
  endfunction

  // Expected bin list {val, ep, ctx} from the syntax rules
  function automatic void build_exp(input logic signed [15:0] x,
                                    input logic signed [15:0] y,
                                    input logic [1:0] st, input bit ci);
    int a[2];
    int s[2];
    int it, v, k;
    exp_q.delete();
    it = (st == 2'd1) ? (ci ? 2 : 1) : (st == 2'd0) ? (ci ? 1 : 2) : 0;
    a[0] = (x < 0) ? -int'(x) : int'(x);
    a[1] = (y < 0) ? -int'(y) : int'(y);
    s[0] = (x < 0) ? 1 : 0;
    s[1] = (y < 0) ? 1 : 0;
    for (int c = 0; c < 2; c++)
      exp_q.push_back(mk(a[c] > 0, 1'b0, CTXIDX_ABS_MVD_GT0_FLAG[it]));
    for (int c = 0; c < 2; c++)
      if (a[c] > 0)
        exp_q.push_back(mk(a[c] > 1, 1'b0, CTXIDX_ABS_MVD_GT1_FLAG[it]));
    for (int c = 0; c < 2; c++) begin
      if (a[c] > 1) begin
        v = a[c] - 2;
        k = 1;
        while (v >= (1 << k)) begin
          exp_q.push_back(mk(1, 1'b1, 10'd0));
          v -= (1 << k);
          k++;
        end
        exp_q.push_back(mk(0, 1'b1, 10'd0));
        for (int i = k - 1; i >= 0; i--)
          exp_q.push_back(mk((v >> i) & 1, 1'b1, 10'd0));
      end
      if (a[c] > 0) exp_q.push_back(mk(s[c], 1'b1, 10'd0));
    end
  endfunction

  // abort_at >= 0: pull reset after that many bins were accepted
  task automatic run_mvd(input string nm, input logic [15:0] x,
                         input logic [15:0] y, input logic [1:0] st,
                         input bit ci, input int pct, input bit poke,
                         input int abort_at);
    int cyc, got;
    bit done_seen, p_stall;
    logic [12:0] prev, cur;
    build_exp(x, y, st, ci);
    @(negedge clk);
    mvd_x = x;
    mvd_y = y;
    slice_type = st;
    cabac_init_flag = ci;
    mvd_start = 1'b1;
    bin_rdy = 1'b1;
    cyc = 0;
    got = 0;
    done_seen = 0;
    p_stall = 0;
    prev = '0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      mvd_start = 1'b0;
      if (abort_at >= 0 && got == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_vld"}, 32'(bin_vld), 32'd0);
        chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk({nm, "_rst_done"}, 32'(mvd_done_intr), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk({nm, "_post_rst_done"}, 32'(mvd_done_intr), 32'd0);
        chk({nm, "_post_rst_vld"}, 32'(bin_vld), 32'd0);
        return;
      end
      cur = {bin_vld, bin_val, bin_ep_mode, bin_ctx_addr};
      if (p_stall) chk({nm, "_stall_hold"}, 32'(cur), 32'(prev));
      if (mvd_done_intr) begin
        done_seen = 1;
        chk({nm, "_nbins"}, 32'(got), 32'(exp_q.size()));
        chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        if (pct == 100)
          chk({nm, "_done_lat"}, 32'(cyc), 32'(exp_q.size() + 1));
      end else begin
        chk({nm, "_busy"}, 32'(busy), 32'd1);
      end
      bin_rdy = ($urandom_range(99) < pct);
      if (bin_vld && bin_rdy) begin
        if (got < exp_q.size())
          chk($sformatf("%s_bin%0d", nm, got),
              32'({bin_val, bin_ep_mode, bin_ctx_addr}), 32'(exp_q[got]));
        else
          chk({nm, "_extra_bin"}, 32'(got), 32'(exp_q.size()));
        got++;
      end
      p_stall = bin_vld && !bin_rdy;
      prev = cur;
      if (poke && busy && !mvd_done_intr && $urandom_range(3) == 0) begin
        mvd_start = 1'b1;
        mvd_x = 16'($urandom);
        mvd_y = 16'($urandom);
        slice_type = 2'($urandom_range(2));
      end
    end
    mvd_start = 1'b0;
    if (!done_seen) chk({nm, "_timeout"}, 32'(cyc), 32'd0);
  endtask

  initial begin
    logic [15:0] rx, ry;
    int mode;
    rst_n = 1'b0;
    mvd_start = 1'b0;
    mvd_x = '0;
    mvd_y = '0;
    slice_type = 2'd0;
    cabac_init_flag = 1'b0;
    bin_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(bin_vld), 32'd0);
    chk("rst_val", 32'(bin_val), 32'd0);
    chk("rst_ep", 32'(bin_ep_mode), 32'd0);
    chk("rst_ctx", 32'(bin_ctx_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(mvd_done_intr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_mvd("c1", 16'sd0, 16'sd0, SLICE_P, 1'b0, 100, 1'b0, -1);
    run_mvd("c2", 16'sd1, -16'sd1, SLICE_P, 1'b0, 100, 1'b0, -1);
    run_mvd("c3", 16'sd5, 16'sd0, SLICE_B, 1'b1, 100, 1'b0, -1);
    run_mvd("c4", 16'h8000, 16'sd3, SLICE_P, 1'b1, 100, 1'b0, -1);
    run_mvd("c5", 16'sd5, 16'sd0, SLICE_B, 1'b1, 30, 1'b1, -1);
    run_mvd("c6a", 16'h8000, 16'sd3, SLICE_B, 1'b0, 100, 1'b0, 6);
    run_mvd("c6b", 16'sd1, -16'sd1, SLICE_P, 1'b0, 100, 1'b0, -1);
    run_mvd("islice", -16'sd7, 16'sd2, SLICE_I, 1'b1, 100, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      mode = int'($urandom_range(2));
      case (mode)
        0: begin
          rx = 16'(int'($urandom_range(8)) - 4);
          ry = 16'(int'($urandom_range(8)) - 4);
        end
        1: begin
          rx = 16'(int'($urandom_range(600)) - 300);
          ry = 16'(int'($urandom_range(600)) - 300);
        end
        default: begin
          rx = 16'($urandom);
          ry = 16'($urandom);
        end
      endcase
      run_mvd($sformatf("rnd%0d", n), rx, ry, 2'($urandom_range(2)),
              1'($urandom), (n % 3 == 0) ? 100 : 60, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
